// File: rtl/multicycle_alu_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_alu_unit_if
//  Description : Request/response bundle for the multi-cycle ALU. The master
//                side issues operations and consumes results; the slave side
//                is the ALU itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_alu_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [1:0]      alu_ctrl_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            bcond;
    logic            busy;

    modport master (
        output flush, in_valid, inst, alu_ctrl_op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, bcond, busy
    );

    modport slave (
        input  flush, in_valid, inst, alu_ctrl_op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, bcond, busy
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_alu_unit
//  Description : Decoding ALU with single-cycle integer ops plus iterative
//                unsigned multiply (shift-add) and divide (restoring), one
//                bit per cycle. Valid/ready handshake with flush support.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_alu_unit_if.slave bus
);

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // Internal operation codes
    localparam logic [3:0] c_OP_ADD   = 4'd0;
    localparam logic [3:0] c_OP_SUB   = 4'd1;
    localparam logic [3:0] c_OP_SLL   = 4'd2;
    localparam logic [3:0] c_OP_SRL   = 4'd3;
    localparam logic [3:0] c_OP_SRA   = 4'd4;
    localparam logic [3:0] c_OP_XOR   = 4'd5;
    localparam logic [3:0] c_OP_OR    = 4'd6;
    localparam logic [3:0] c_OP_AND   = 4'd7;
    localparam logic [3:0] c_OP_SLT   = 4'd8;
    localparam logic [3:0] c_OP_SLTU  = 4'd9;
    localparam logic [3:0] c_OP_MUL   = 4'd10;
    localparam logic [3:0] c_OP_MULHU = 4'd11;
    localparam logic [3:0] c_OP_DIVU  = 4'd12;
    localparam logic [3:0] c_OP_REMU  = 4'd13;

    // Instruction fields of interest (LOAD/STORE/JALR and unknown opcodes decode to ADD)
    localparam logic [6:0] c_OPC_R      = 7'b0110011;
    localparam logic [6:0] c_OPC_I      = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;
    localparam logic [6:0] c_F7_MULDIV  = 7'b0000001;

    localparam logic [SHW-1:0] c_LAST_ITER = SHW'(XLEN - 1);

    logic [1:0]      r_state;
    logic [3:0]      r_op;
    logic [SHW-1:0]  r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opnd;
    logic [XLEN-1:0] r_result;
    logic            r_out_valid;
    logic            r_bcond;
    logic            r_busy;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic            w_is_rtype;
    logic            w_is_branch;
    logic            w_is_arith;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic [SHW-1:0]  w_shamt;
    logic [3:0]      w_op;
    logic            w_bcond;
    logic            w_multi;
    logic            w_is_mul;
    logic [XLEN-1:0] w_single;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN-1:0] w_mul_hi;
    logic [XLEN-1:0] w_mul_lo;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ge;
    logic [XLEN-1:0] w_div_hi;
    logic [XLEN-1:0] w_div_lo;
    logic            w_unused;

    assign w_opcode    = bus.inst[6:0];
    assign w_funct3    = bus.inst[14:12];
    assign w_funct7    = bus.inst[31:25];
    assign w_unused    = ^{bus.inst[24:15], bus.inst[11:7]};
    assign w_is_rtype  = (w_opcode == c_OPC_R);
    assign w_is_branch = (bus.alu_ctrl_op == 2'b01) ||
                         (bus.alu_ctrl_op == 2'b11 && w_opcode == c_OPC_BRANCH);
    assign w_is_arith  = (bus.alu_ctrl_op == 2'b10) ||
                         (bus.alu_ctrl_op == 2'b11 && (w_opcode == c_OPC_R || w_opcode == c_OPC_I));

    assign w_sum   = bus.op_a + bus.op_b;
    assign w_diff  = bus.op_a - bus.op_b;
    assign w_eq    = (w_diff == '0);
    assign w_lt    = ($signed(bus.op_a) < $signed(bus.op_b));
    assign w_ltu   = (bus.op_a < bus.op_b);
    assign w_shamt = bus.op_b[SHW-1:0];

    assign w_multi  = (w_op == c_OP_MUL) || (w_op == c_OP_MULHU) ||
                      (w_op == c_OP_DIVU) || (w_op == c_OP_REMU);
    assign w_is_mul = (w_op == c_OP_MUL) || (w_op == c_OP_MULHU);

    // Decode instruction + control op into an internal op and branch flag
    always_comb begin
        w_op    = c_OP_ADD;
        w_bcond = 1'b0;
        if (w_is_branch) begin
            case (w_funct3)
                3'b000:  begin w_op = c_OP_SUB;  w_bcond = w_eq;   end
                3'b001:  begin w_op = c_OP_SUB;  w_bcond = !w_eq;  end
                3'b100:  begin w_op = c_OP_SLT;  w_bcond = w_lt;   end
                3'b101:  begin w_op = c_OP_SLT;  w_bcond = !w_lt;  end
                3'b110:  begin w_op = c_OP_SLTU; w_bcond = w_ltu;  end
                3'b111:  begin w_op = c_OP_SLTU; w_bcond = !w_ltu; end
                default: ;
            endcase
        end else if (w_is_arith) begin
            if (w_is_rtype && w_funct7 == c_F7_MULDIV) begin
                case (w_funct3)
                    3'b000:  w_op = c_OP_MUL;
                    3'b011:  w_op = c_OP_MULHU;
                    3'b101:  w_op = c_OP_DIVU;
                    3'b111:  w_op = c_OP_REMU;
                    default: ;
                endcase
            end else begin
                case (w_funct3)
                    3'b000:  w_op = (w_is_rtype && w_funct7 == c_F7_ALT) ? c_OP_SUB : c_OP_ADD;
                    3'b001:  w_op = c_OP_SLL;
                    3'b010:  w_op = c_OP_SLT;
                    3'b011:  w_op = c_OP_SLTU;
                    3'b100:  w_op = c_OP_XOR;
                    3'b101:  w_op = (w_funct7 == c_F7_ALT) ? c_OP_SRA : c_OP_SRL;
                    3'b110:  w_op = c_OP_OR;
                    default: w_op = c_OP_AND;
                endcase
            end
        end
    end

    // Single-cycle result computed straight from the request operands
    always_comb begin
        case (w_op)
            c_OP_SUB:  w_single = w_diff;
            c_OP_SLL:  w_single = bus.op_a << w_shamt;
            c_OP_SRL:  w_single = bus.op_a >> w_shamt;
            c_OP_SRA:  w_single = $unsigned($signed(bus.op_a) >>> w_shamt);
            c_OP_XOR:  w_single = bus.op_a ^ bus.op_b;
            c_OP_OR:   w_single = bus.op_a | bus.op_b;
            c_OP_AND:  w_single = bus.op_a & bus.op_b;
            c_OP_SLT:  w_single = {{(XLEN-1){1'b0}}, w_lt};
            c_OP_SLTU: w_single = {{(XLEN-1){1'b0}}, w_ltu};
            default:   w_single = w_sum;
        endcase
    end

    // Shift-add step: {hi,lo} holds partial product and unconsumed multiplier bits
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[XLEN:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[XLEN-1:1]};

    // Restoring step: hi is the remainder, lo shifts dividend out and quotient in.
    // A zero divisor always subtracts, giving all-ones quotient and remainder = dividend.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = !w_div_diff[XLEN];
    assign w_div_hi    = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    assign w_div_lo    = {r_lo[XLEN-2:0], w_div_ge};

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_bcond     <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else if (bus.flush) begin
            r_state     <= c_ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_op  <= w_op;
                        r_cnt <= '0;
                        if (w_multi) begin
                            r_state <= w_is_mul ? c_ST_MUL : c_ST_DIV;
                            r_busy  <= 1'b1;
                            r_bcond <= 1'b0;
                            r_hi    <= '0;
                            r_lo    <= w_is_mul ? bus.op_b : bus.op_a;
                            r_opnd  <= w_is_mul ? bus.op_a : bus.op_b;
                        end else begin
                            r_state     <= c_ST_DONE;
                            r_result    <= w_single;
                            r_bcond     <= w_bcond;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                c_ST_MUL: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_result    <= (r_op == c_OP_MULHU) ? w_mul_hi : w_mul_lo;
                        r_state     <= c_ST_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                c_ST_DIV: begin
                    r_hi  <= w_div_hi;
                    r_lo  <= w_div_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_result    <= (r_op == c_OP_REMU) ? w_div_hi : w_div_lo;
                        r_state     <= c_ST_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        r_state     <= c_ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_ST_IDLE) && !reset;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.bcond     = r_bcond;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_alu_unit
//  Description : Scoreboard bench for multicycle_alu_unit: directed cases plus
//                random requests checked against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu_unit;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] res;
        logic        bc;
        string       name;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    exp_t exp_q[$];

    multicycle_alu_unit_if #(.XLEN(XLEN)) bus ();

    multicycle_alu_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 10'h0, f3, 5'h0, opc};
    endfunction

    // Reference model: derives the answer from the decode rules using plain arithmetic
    function automatic void ref_model(input logic [1:0] ctrl, input logic [31:0] ins,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic bc, output bit multi);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] prod;
        bit          branch;
        bit          arith;
        bit          slt;
        bit          sltu;
        opc    = ins[6:0];
        f3     = ins[14:12];
        f7     = ins[31:25];
        prod   = {32'h0, a} * {32'h0, b};
        slt    = ($signed(a) < $signed(b));
        sltu   = (a < b);
        branch = (ctrl == 2'd1) || (ctrl == 2'd3 && opc == 7'b1100011);
        arith  = (ctrl == 2'd2) || (ctrl == 2'd3 && (opc == 7'b0110011 || opc == 7'b0010011));
        r      = a + b;
        bc     = 1'b0;
        multi  = 1'b0;
        if (branch) begin
            case (f3)
                3'd0: begin r = a - b; bc = (a == b); end
                3'd1: begin r = a - b; bc = (a != b); end
                3'd4: begin r = 32'(slt);  bc = slt;   end
                3'd5: begin r = 32'(slt);  bc = !slt;  end
                3'd6: begin r = 32'(sltu); bc = sltu;  end
                3'd7: begin r = 32'(sltu); bc = !sltu; end
                default: ;
            endcase
        end else if (arith) begin
            if (opc == 7'b0110011 && f7 == 7'd1) begin
                case (f3)
                    3'd0: begin multi = 1; r = prod[31:0]; end
                    3'd3: begin multi = 1; r = prod[63:32]; end
                    3'd5: begin multi = 1; r = (b == 0) ? 32'hFFFF_FFFF : a / b; end
                    3'd7: begin multi = 1; r = (b == 0) ? a : a % b; end
                    default: ;
                endcase
            end else begin
                case (f3)
                    3'd0: r = (opc == 7'b0110011 && f7 == 7'b0100000) ? a - b : a + b;
                    3'd1: r = a << b[4:0];
                    3'd2: r = 32'(slt);
                    3'd3: r = 32'(sltu);
                    3'd4: r = a ^ b;
                    3'd5: r = (f7 == 7'b0100000) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
            end
        end
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    endtask

    // Issue one request, push its expectation, then follow it to completion
    task automatic run_op(input string name, input logic [1:0] ctrl, input logic [31:0] ins,
                          input logic [31:0] a, input logic [31:0] b, output logic [31:0] er);
        logic eb;
        bit   multi;
        int   lat;
        int   busy_n;
        bit   rdy_seen;
        exp_t e;
        ref_model(ctrl, ins, a, b, er, eb, multi);
        wait_ready();
        bus.in_valid    = 1'b1;
        bus.alu_ctrl_op = ctrl;
        bus.inst        = ins;
        bus.op_a        = a;
        bus.op_b        = b;
        e.res  = er;
        e.bc   = eb;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat      = 0;
        busy_n   = 0;
        rdy_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            if (bus.in_ready) rdy_seen = 1;
        end while (!bus.out_valid && lat < 200);
        check({name, "_latency"}, lat, multi ? XLEN + 1 : 1);
        if (multi) check({name, "_busy_cycles"}, busy_n, XLEN);
        check({name, "_in_ready_low"}, rdy_seen, 0);
    endtask

    // Monitor: compare every consumed result against the scoreboard head
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got result 0x%0h required no output", bus.result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_result"}, bus.result, e.res);
                check({e.name, "_bcond"}, bus.bcond, e.bc);
            end
        end
    end

    initial begin
        logic [31:0] er;
        logic [6:0]  opcs[7];
        logic [6:0]  f7s[4];
        int          seen;
        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111, 7'b1100011, 7'b1111111};
        f7s  = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b1010101};
        n_cmp = 0;
        n_fail = 0;
        reset           = 1'b1;
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.inst        = '0;
        bus.alu_ctrl_op = '0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.out_ready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_bcond", bus.bcond, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases
        run_op("sub_r", 2'b10, mk(7'b0100000, 3'b000, 7'b0110011), 32'd5, 32'd7, er);
        check("sub_r_const", er, 32'hFFFF_FFFE);
        run_op("blt", 2'b01, mk(7'h0, 3'b100, 7'b1100011), 32'hFFFF_FFFF, 32'd1, er);
        run_op("bltu", 2'b01, mk(7'h0, 3'b110, 7'b1100011), 32'hFFFF_FFFF, 32'd1, er);
        run_op("beq_dec", 2'b11, mk(7'h0, 3'b000, 7'b1100011), 32'd9, 32'd9, er);
        run_op("mul", 2'b10, mk(7'd1, 3'b000, 7'b0110011), 32'hFFFF_FFFF, 32'hFFFF_FFFF, er);
        check("mul_const", er, 32'h1);
        run_op("mulhu", 2'b10, mk(7'd1, 3'b011, 7'b0110011), 32'hFFFF_FFFF, 32'hFFFF_FFFF, er);
        check("mulhu_const", er, 32'hFFFF_FFFE);
        run_op("divu", 2'b10, mk(7'd1, 3'b101, 7'b0110011), 32'd100, 32'd7, er);
        check("divu_const", er, 32'd14);
        run_op("remu", 2'b10, mk(7'd1, 3'b111, 7'b0110011), 32'd100, 32'd7, er);
        check("remu_const", er, 32'd2);
        run_op("divu0", 2'b10, mk(7'd1, 3'b101, 7'b0110011), 32'd100, 32'd0, er);
        check("divu0_const", er, 32'hFFFF_FFFF);
        run_op("remu0", 2'b10, mk(7'd1, 3'b111, 7'b0110011), 32'd100, 32'd0, er);
        check("remu0_const", er, 32'd100);
        run_op("sra", 2'b10, mk(7'b0100000, 3'b101, 7'b0010011), 32'h8000_0000, 32'd36, er);

        // Backpressure: result must hold in DONE
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        run_op("hold", 2'b10, mk(7'd1, 3'b101, 7'b0110011), 32'd100, 32'd7, er);
        repeat (5) begin
            @(negedge clk);
            check("hold_result", bus.result, er);
            check("hold_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_valid", bus.out_valid, 0);
        check("release_in_ready", bus.in_ready, 1);

        // Flush at iteration 10 of a divide
        bus.in_valid    = 1'b1;
        bus.alu_ctrl_op = 2'b10;
        bus.inst        = mk(7'd1, 3'b101, 7'b0110011);
        bus.op_a        = 32'd1000;
        bus.op_b        = 32'd3;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", bus.in_ready, 1);
        check("flush_busy", bus.busy, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("flush_no_output", seen, 0);

        // Flush takes priority over a simultaneous accept
        bus.in_valid    = 1'b1;
        bus.flush       = 1'b1;
        bus.alu_ctrl_op = 2'b00;
        bus.op_a        = 32'd1;
        bus.op_b        = 32'd1;
        @(posedge clk);
        #1 begin bus.in_valid = 1'b0; bus.flush = 1'b0; end
        @(negedge clk);
        check("flush_accept_valid", bus.out_valid, 0);
        check("flush_accept_in_ready", bus.in_ready, 1);

        run_op("add_after_flush", 2'b00, 32'h0, 32'd2, 32'd3, er);
        check("add_after_flush_const", er, 32'd5);

        // Random requests
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [1:0]  ctrl;
            logic [31:0] ins;
            a    = $urandom_range(0, 3) == 0 ? $urandom_range(0, 50) : $urandom;
            b    = $urandom_range(0, 3) == 0 ? $urandom_range(0, 9) : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            ctrl = 2'($urandom_range(0, 3));
            ins  = mk(f7s[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), opcs[$urandom_range(0, 6)]);
            ins[24:15] = 10'($urandom);
            ins[11:7]  = 5'($urandom);
            run_op($sformatf("rnd%0d", i), ctrl, ins, a, b, er);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_alu_unit.md
Name: multicycle_alu_unit

Overview:
- Parametrised successor to the combinational ALU control decode: decodes the instruction and ALU control op, then executes the operation in one block.
- Adds RV32M-style unsigned multiply/divide (MUL, MULHU, DIVU, REMU) via an iterative XLEN-cycle datapath.
- Uses a valid/ready handshake and supports a pipeline flush.
- Sits between operand fetch and writeback/branch logic of the multi-cycle CPU.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, at least 8.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- flush  in  1  abort any in-flight or completed-but-unconsumed op.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- inst  in  32  full instruction word; opcode [6:0], funct3 [14:12], funct7 [31:25].
- alu_ctrl_op  in  2  00=add (addressing), 01=branch compare, 10=R-type/I-type decode, 11=decode from opcode.
- op_a  in  XLEN  operand A.
- op_b  in  XLEN  operand B (register or immediate, muxed upstream).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- bcond  out  1  branch-taken flag; meaningful only for alu_ctrl_op=01.
- busy  out  1  high in MUL_ITER or DIV_ITER.

Behaviour:
- Reset (synchronous, active-high) sets: state=IDLE, out_valid=0, result=0, bcond=0, busy=0, iteration counter=0.
- in_ready = (state==IDLE) and !reset. A request is accepted on the edge where in_valid and in_ready are both high. Operands and the decoded op are latched at accept.
- Decode rules (evaluated at accept):
  - 00: ADD.
  - 01: funct3 000/001 -> SUB, bcond = (diff==0) for 000, !(diff==0) for 001. 100/101 -> signed less-than, bcond = lt for 100, !lt for 101. 110/111 -> unsigned less-than, bcond likewise. Other funct3 -> ADD, bcond=0.
  - 10 (or 11 with opcode ARITHMETIC/ARITHMETIC_IMM):
    - funct3 000 -> SUB only if R-type and funct7=0100000, else ADD.
    - 001 -> SLL. 100 -> XOR. 110 -> OR. 111 -> AND. 010 -> SLT. 011 -> SLTU.
    - 101 -> SRA if funct7=0100000, else SRL.
    - R-type with funct7=0000001: funct3 000=MUL, 011=MULHU, 101=DIVU, 111=REMU. Other M encodings -> ADD.
  - 11 with LOAD/STORE/JALR -> ADD. 11 with BRANCH -> as 01. Any other opcode -> ADD.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN. Shifts use op_b[SHW-1:0] only. SLT/SLTU return 1 or 0, zero-extended.
- States: IDLE, MUL_ITER, DIV_ITER, DONE.
  - IDLE + accept of a single-cycle op -> DONE. result/bcond registered on the accept edge; out_valid=1 the next cycle (latency 1).
  - IDLE + accept of MUL/MULHU -> MUL_ITER. Shift-add, one bit per cycle, 2*XLEN-bit product. After exactly XLEN iterations -> DONE. MUL returns product[XLEN-1:0]; MULHU returns product[2*XLEN-1:XLEN]. out_valid asserts XLEN+1 cycles after accept.
  - IDLE + accept of DIVU/REMU -> DIV_ITER. Restoring division, one quotient bit per cycle, XLEN iterations -> DONE, same latency as multiply.
  - Divide by zero still takes the full XLEN cycles: DIVU returns all ones, REMU returns op_a.
  - DONE: out_valid=1; result and bcond held stable until out_ready=1, then -> IDLE next cycle with out_valid=0. No new accept while in DONE.
- flush=1 in any state -> IDLE on that edge, out_valid=0, busy=0, no result produced. flush overrides a simultaneous accept; the request is dropped.
- reset mid-iteration behaves as flush plus result/bcond clearing.
- bcond=0 for any non-branch op.

Test Plan:
- Reset, then alu_ctrl_op=10, inst funct3=000 funct7=0100000 R-type, op_a=5, op_b=7, in_valid=1 -> accept with in_ready=1; next cycle out_valid=1, result=0xFFFFFFFE.
- alu_ctrl_op=01, funct3=100 (BLT), op_a=0xFFFFFFFF, op_b=1 -> bcond=1. Repeat with funct3=110 (BLTU) -> bcond=0.
- MUL/MULHU with op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> busy for 32 cycles; out_valid at cycle 33. MUL result=0x00000001, MULHU result=0xFFFFFFFE; in_ready=0 throughout.
- DIVU op_a=100, op_b=7 -> result=14 after 33 cycles. REMU -> 2. DIVU by 0 -> 0xFFFFFFFF. REMU by 0 -> 100.
- DONE with out_ready=0 for 5 cycles -> result held and in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- flush at iteration 10 of DIVU -> out_valid never asserts; IDLE next cycle. A new ADD 2+3 is then accepted and returns 5.
